// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared op and FSM state encodings for the EX-stage multiply/divide unit
package ex_muldiv_pkg;
    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;
    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;
endpackage

// File: rtl/ex_muldiv_div_core.sv
// ex_muldiv_div_core: iterative unsigned restoring divider, one quotient bit per cycle
//   clk, rst (async active-low), i_start loads operands, i_cancel aborts (sync),
//   o_done high during the last iteration, o_quotient/o_remainder valid the cycle after
module ex_muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_sub;
    // partial remainder shifted left with the next dividend bit; remainder < divisor keeps it in WIDTH+1 bits
    assign w_sh        = {r_rem, r_quo[WIDTH-1]};
    assign w_sub       = w_sh - {1'b0, r_div};
    assign o_done      = r_cnt == CW'(1);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_cancel) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= CW'(WIDTH);
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_sub[WIDTH] ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit that stalls EX and writes HI/LO once
//   clk, rst (async active-low), start/op/operand_1/operand_2 from EX, flush cancels,
//   stall_request holds IF..EX, busy = not idle, hilo_write_en strobes hi_out/lo_out
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             flush,
    output logic             stall_request,
    output logic             busy,
    output logic             hilo_write_en,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(MUL_CYCLES + 1);
    md_state_e          r_state;
    md_state_e          w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_dz;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod [MUL_CYCLES];
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_dz_in;
    logic               w_sgn_in;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_done;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_smul;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_sdiv;
    logic               w_wr;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    assign w_accept = r_state == MD_IDLE && start && !flush;
    assign w_dz_in  = operand_2 == '0;
    assign w_sgn_in = op == MD_OP_DIV;
    assign w_mag_a  = (w_sgn_in && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign w_mag_b  = (w_sgn_in && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
    ex_muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept && op[1] && !w_dz_in),
        .i_cancel    (flush),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );
    // a 2W-bit product of sign/zero-extended operands is exact for both MULT and MULTU
    assign w_smul   = r_op == MD_OP_MULT;
    assign w_ext_a  = {{WIDTH{w_smul && r_a[WIDTH-1]}}, r_a};
    assign w_ext_b  = {{WIDTH{w_smul && r_b[WIDTH-1]}}, r_b};
    assign w_prod   = w_ext_a * w_ext_b;
    assign w_sdiv   = r_op == MD_OP_DIV;
    assign w_res_hi = !r_op[1] ? r_prod[MUL_CYCLES-1][2*WIDTH-1:WIDTH] : r_dz ? r_a : r_r;
    assign w_res_lo = !r_op[1] ? r_prod[MUL_CYCLES-1][WIDTH-1:0] : r_dz ? '1 : r_q;
    assign w_wr          = r_state == MD_DONE && !flush;
    assign hilo_write_en = w_wr;
    assign hi_out        = w_wr ? w_res_hi : r_hi;
    assign lo_out        = w_wr ? w_res_lo : r_lo;
    assign busy          = r_state != MD_IDLE;
    assign stall_request = w_accept || r_state == MD_MUL || r_state == MD_DIV || r_state == MD_FIX;
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (start) w_next = !op[1] ? MD_MUL : w_dz_in ? MD_DONE : MD_DIV;
                MD_MUL:  if (r_cnt == CW'(MUL_CYCLES - 1)) w_next = MD_DONE;
                MD_DIV:  if (w_done) w_next = MD_FIX;
                MD_FIX:  w_next = MD_DONE;
                default: w_next = MD_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MD_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            for (int i = 0; i < MUL_CYCLES; i++) r_prod[i] <= '0;
        end else begin
            r_state <= w_next;
            r_prod[0] <= w_prod;
            for (int i = 1; i < MUL_CYCLES; i++) r_prod[i] <= r_prod[i-1];
            if (w_accept) begin
                r_a   <= operand_1;
                r_b   <= operand_2;
                r_op  <= op;
                r_dz  <= w_dz_in;
                r_cnt <= '0;
            end
            if (r_state == MD_MUL) r_cnt <= r_cnt + CW'(1);
            // quotient negative when signs differ; remainder follows the dividend
            if (r_state == MD_FIX) begin
                r_q <= (w_sdiv && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_quo : w_quo;
                r_r <= (w_sdiv && r_a[WIDTH-1]) ? -w_rem : w_rem;
            end
            if (w_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end
endmodule
